// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension stage: format select codes and entry layout.
package imm_pkg;

    localparam int IMMSRC_W = 3;

    typedef enum logic [IMMSRC_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4,
        IMM_Z = 3'd5
    } immsrc_e;

    // Widest-case entry layout (RV64 immediate, 64-bit tag); the pipe narrows per its parameters.
    typedef struct packed {
        logic [63:0] immext;
        logic [63:0] tag;
        logic        err;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: instr[31:7] + format select -> XLEN-wide immediate.
// The err port exists only when IMMEXT_ERR_EN is defined.
module imm_gen
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]          instr,
    input  logic [IMMSRC_W-1:0]  immsrc,
    output logic [XLEN-1:0]      immext
`ifdef IMMEXT_ERR_EN
    ,
    output logic                 err
`endif
);

    // instr[k] here is instruction bit k+7
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (immsrc_e'(immsrc))
            IMM_I:   imm32 = {{20{instr[24]}}, instr[24:13]};
            IMM_S:   imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            IMM_B:   imm32 = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:   imm32 = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U:   imm32 = {instr[24:5], 12'b0};
            IMM_Z:   imm32 = {27'b0, instr[12:8]};
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_rv64
            assign immext = {{32{imm32[31]}}, imm32};
        end else begin : g_rv32
            assign immext = imm32;
        end
    endgenerate

`ifdef IMMEXT_ERR_EN
    // codes 110 and 111 are the reserved ones
    assign err = immsrc[2] & immsrc[1];
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Buffered immediate-extension stage: imm_gen feeding a DEPTH-entry valid/ready FIFO with tag sideband.
// Define IMMEXT_ERR_EN to store and report reserved-format errors on out_err.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [24:0]              in_instr,
    input  logic [IMMSRC_W-1:0]      in_immsrc,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_immext,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_en;

    logic [XLEN-1:0]  gen_immext;
    logic [XLEN-1:0]  immext_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem    [DEPTH];

`ifdef IMMEXT_ERR_EN
    logic             gen_err;
    logic             err_mem    [DEPTH];
`endif

    imm_gen #(
        .XLEN   (XLEN)
    ) u_imm_gen (
        .instr  (in_instr),
        .immsrc (in_immsrc),
        .immext (gen_immext)
`ifdef IMMEXT_ERR_EN
        ,
        .err    (gen_err)
`endif
    );

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                immext_mem[k] <= '0;
                tag_mem[k]    <= '0;
`ifdef IMMEXT_ERR_EN
                err_mem[k]    <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_en[k]) begin
                    immext_mem[k] <= gen_immext;
                    tag_mem[k]    <= in_tag;
`ifdef IMMEXT_ERR_EN
                    err_mem[k]    <= gen_err;
`endif
                end
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_immext = immext_mem[rd_ptr_reg];
    assign out_tag    = tag_mem[rd_ptr_reg];
    assign count      = count_reg;
`ifdef IMMEXT_ERR_EN
    assign out_err    = err_mem[rd_ptr_reg];
`else
    assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: XLEN=32 and XLEN=64 instances driven in lockstep, scoreboard-checked.
module tb_imm_extend_pipe;

`ifdef IMMEXT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  src;
        logic [31:0] instr;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_immext32, out_tag32;
    logic [1:0]  count32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_immext64;
    logic [31:0] out_tag64;
    logic [1:0]  count64;

    int checks = 0;
    int fails  = 0;
    exp_t sb[$];
    exp_t cur_exp;
    vec_t vecs[13];

    imm_extend_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_immext(out_immext32),
        .out_tag(out_tag32), .out_err(out_err32), .count(count32)
    );

    imm_extend_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_immext(out_immext64),
        .out_tag(out_tag64), .out_err(out_err64), .count(count64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [31:0] tag);
        in_valid  = 1'b1;
        in_instr  = v.instr[31:7];
        in_immsrc = v.src;
        in_tag    = tag;
        cur_exp   = '{v.e32, v.e64, tag, v.err};
    endtask

    // Called right after a negedge with inputs set; checks just before the next posedge.
    task automatic tick();
        exp_t e;
        #4;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid32 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 64'(out_tag32), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("immext32", 64'(out_immext32), 64'(e.e32));
                    chk("immext64", out_immext64, e.e64);
                    chk("tag32", 64'(out_tag32), 64'(e.tag));
                    chk("tag64", 64'(out_tag64), 64'(e.tag));
                    chk("err32", 64'(out_err32), 64'(e.err));
                    chk("valid64", 64'(out_valid64), 64'd1);
                    $display("pop tag=%h imm32=%h imm64=%h err=%b", out_tag32, out_immext32, out_immext64, out_err32);
                end
            end
            if (in_valid && in_ready32) begin
                sb.push_back(cur_exp);
                $display("push tag=%h src=%0d instr=%h", in_tag, in_immsrc, in_instr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{3'd1, 32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2]  = '{3'd2, 32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vecs[3]  = '{3'd3, 32'h0010006F, 32'h00000800, 64'h0000000000000800, 1'b0};
        vecs[4]  = '{3'd5, 32'h300FD073, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[5]  = '{3'd4, 32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[6]  = '{3'd0, 32'h7FF00093, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[7]  = '{3'd4, 32'h12345037, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[8]  = '{3'd1, 32'h00112423, 32'h00000008, 64'h0000000000000008, 1'b0};
        vecs[9]  = '{3'd5, 32'hFFFFFFFF, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[10] = '{3'd6, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000, ERR_EN};
        vecs[11] = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000, ERR_EN};
        vecs[12] = '{3'd3, 32'h8000006F, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        chk("rst_count", 64'(count32), 64'd0);
        chk("rst_immext64", out_immext64, 64'd0);
        reset_n = 1'b1;

        // Streaming table: one push per cycle, popped one cycle later
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i], 32'hA0000000 + 32'(i));
            tick();
        end
        drain();

        // Full FIFO back-pressure, then in-order drain
        out_ready = 1'b0;
        drive(vecs[1], 32'hB0000001); tick();
        drive(vecs[2], 32'hB0000002); tick();
        chk("full_in_ready", 64'(in_ready32), 64'd0);
        chk("full_count32", 64'(count32), 64'd2);
        chk("full_count64", 64'(count64), 64'd2);
        drive(vecs[3], 32'hB0000003); tick(); tick();
        chk("full_hold_count", 64'(count32), 64'd2);
        chk("full_hold_tag", 64'(out_tag32), 64'hB0000001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("after_drain_count", 64'(count32), 64'd0);

        // Simultaneous push+pop at count 1, then flush with a push
        out_ready = 1'b0;
        drive(vecs[4], 32'hC0000001); tick();
        chk("one_count", 64'(count32), 64'd1);
        out_ready = 1'b1;
        drive(vecs[5], 32'hC0000002); tick();
        chk("pushpop_count", 64'(count32), 64'd1);
        out_ready = 1'b0;
        drive(vecs[6], 32'hC0000003);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count32), 64'd0);
        chk("flush_out_valid", 64'(out_valid32), 64'd0);
        out_ready = 1'b1;
        drive(vecs[7], 32'hC0000004); tick();
        drain();

        // Asynchronous reset with a full FIFO
        out_ready = 1'b0;
        drive(vecs[0], 32'hD0000001); tick();
        drive(vecs[12], 32'hD0000002); tick();
        in_valid = 1'b0;
        chk("prerst_count", 64'(count32), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid32), 64'd0);
        chk("arst_in_ready", 64'(in_ready32), 64'd1);
        chk("arst_immext32", 64'(out_immext32), 64'd0);
        chk("arst_immext64", out_immext64, 64'd0);
        chk("arst_tag", 64'(out_tag32), 64'd0);
        chk("arst_err", 64'(out_err32), 64'd0);
        chk("arst_count", 64'(count32), 64'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // Reserved code after reset to confirm the stage resumes cleanly
        out_ready = 1'b1;
        drive(vecs[10], 32'hE0000001); tick();
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
